// File: rtl/multi_nco.sv
// multi_nco: time-multiplexed multi-channel NCO.
// One shared external sine LUT is swept one channel per clock after each
// next_sample pulse; the enabled channel codes are summed into one mixed sample.
// Optional feature macro: MULTI_NCO_PHASE_SYNC_EN (adds per-channel phase_sync).
module multi_nco #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned PA_W   = 24,
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned CODE_W = 14,
  parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int unsigned OUT_W  = CODE_W + CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fcw_wr_en,
  input  logic [CH_W-1:0]   fcw_wr_ch,
  input  logic [PA_W-1:0]   fcw_wr_data,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              next_sample,
`ifdef MULTI_NCO_PHASE_SYNC_EN
  input  logic [N_CH-1:0]   phase_sync,
`endif
  output logic              busy,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [CODE_W-1:0] lut_data,
  output logic [OUT_W-1:0]  sample_out,
  output logic              sample_valid,
  output logic              overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [CH_W-1:0] LastCh = CH_W'(N_CH - 1);

  state_e            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [OUT_W-1:0]  acc_q;
  logic [OUT_W-1:0]  acc_d;
  logic [OUT_W-1:0]  sample_out_q;
  logic              sample_valid_q;
  logic              overrun_q;

  logic [PA_W-1:0]   pa_q  [N_CH];
  logic [PA_W-1:0]   pa_d  [N_CH];
  logic [PA_W-1:0]   fcw_q [N_CH];
  logic [PA_W-1:0]   fcw_d [N_CH];

  logic              run;
  logic [PA_W-1:0]   cur_pa;
  logic              cur_en;
  logic [OUT_W-1:0]  lut_sext;

  assign run          = (state_q == StRun);
  assign busy         = (state_q != StIdle);
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

  // Select the phase and enable of the channel being swept; a loop mux keeps
  // non-power-of-two channel counts free of out-of-range array reads.
  always_comb begin
    cur_pa = '0;
    cur_en = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (ch_q == CH_W'(i)) begin
        cur_pa = pa_q[i];
        cur_en = ch_en[i];
      end
    end
  end

  // LUT address is the pre-update phase of the current channel; parked at 0 otherwise.
  always_comb begin
    lut_addr = '0;
    if (run) begin
      lut_addr = cur_pa[PA_W-1 -: LUT_AW];
    end
  end

  // Sign-extend the LUT code and accumulate it when the channel is enabled.
  always_comb begin
    lut_sext = {{(OUT_W - CODE_W){lut_data[CODE_W-1]}}, lut_data};
    acc_d    = acc_q + (cur_en ? lut_sext : '0);
  end

  // Phase next-state: advance only the swept, enabled channel; sync has priority.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      pa_d[i] = pa_q[i];
      if (run && (ch_q == CH_W'(i)) && ch_en[i]) begin
        pa_d[i] = pa_q[i] + fcw_q[i];
      end
`ifdef MULTI_NCO_PHASE_SYNC_EN
      if (phase_sync[i]) begin
        pa_d[i] = '0;
      end
`endif
    end
  end

  // FCW next-state: out-of-range channel indices match no entry and are dropped.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      fcw_d[i] = fcw_q[i];
      if (fcw_wr_en && (fcw_wr_ch == CH_W'(i))) begin
        fcw_d[i] = fcw_wr_data;
      end
    end
  end

  // Phase accumulator and FCW storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        pa_q[i]  <= '0;
        fcw_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        pa_q[i]  <= pa_d[i];
        fcw_q[i] <= fcw_d[i];
      end
    end
  end

  // Sweep FSM with registered accumulator, sample, valid and overrun outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ch_q           <= '0;
      acc_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      // A request while busy is dropped but remembered until reset.
      if (next_sample && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (next_sample) begin
            state_q <= StRun;
            ch_q    <= '0;
            acc_q   <= '0;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          if (ch_q == LastCh) begin
            state_q <= StDone;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        StDone: begin
          sample_out_q   <= acc_q;
          sample_valid_q <= 1'b1;
          state_q        <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The valid strobe never lasts more than one cycle.
  assert property (@(posedge clk) disable iff (!rst_n) sample_valid_q |=> !sample_valid_q);

endmodule

// File: tb/tb_multi_nco.sv
// Directed testbench for multi_nco (N_CH=4, PA_W=24, LUT_AW=8, CODE_W=14, OUT_W=16).
// The LUT model returns the sign-extended address, or a constant -8192 code.
module tb_multi_nco;

  logic        clk;
  logic        rst_n;
  logic        fcw_wr_en;
  logic [1:0]  fcw_wr_ch;
  logic [23:0] fcw_wr_data;
  logic [3:0]  ch_en;
  logic        next_sample;
`ifdef MULTI_NCO_PHASE_SYNC_EN
  logic [3:0]  phase_sync;
`endif
  logic        busy;
  logic [7:0]  lut_addr;
  logic [13:0] lut_data;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        overrun;

  logic        lut_const;
  int          checks;
  int          errors;
  int          edges;
  logic [7:0]  run_addr [4];

  assign lut_data = lut_const ? 14'h2000 : {{6{lut_addr[7]}}, lut_addr};

  multi_nco dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fcw_wr_en    (fcw_wr_en),
    .fcw_wr_ch    (fcw_wr_ch),
    .fcw_wr_data  (fcw_wr_data),
    .ch_en        (ch_en),
    .next_sample  (next_sample),
`ifdef MULTI_NCO_PHASE_SYNC_EN
    .phase_sync   (phase_sync),
`endif
    .busy         (busy),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    next_sample = 1'b0;
    fcw_wr_en   = 1'b0;
    fcw_wr_ch   = '0;
    fcw_wr_data = '0;
    lut_const   = 1'b0;
`ifdef MULTI_NCO_PHASE_SYNC_EN
    phase_sync  = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_fcw(input logic [1:0] ch, input logic [23:0] d);
    @(negedge clk);
    fcw_wr_en   = 1'b1;
    fcw_wr_ch   = ch;
    fcw_wr_data = d;
    @(negedge clk);
    fcw_wr_en = 1'b0;
  endtask

  // Ends at the negedge right after the edge that accepted next_sample (ch0 RUN).
  task automatic start_sweep();
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    edges       = 0;
    run_addr[0] = lut_addr;
  endtask

  task automatic step();
    @(negedge clk);
    edges++;
    if (edges < 4) run_addr[edges] = lut_addr;
  endtask

  task automatic wait_valid(output int lat);
    while (sample_valid !== 1'b1 && edges < 20) step();
    lat = edges;
  endtask

  task automatic sweep(output int lat);
    start_sweep();
    wait_valid(lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, sample_valid, overrun, sample_out, lut_addr} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0",
               {busy, sample_valid, overrun, sample_out, lut_addr});
    end
    do_reset();
    #1;
    checks++;
    if ({busy, sample_valid, overrun, sample_out} !== 19'd0) begin
      errors++;
      $display("FAIL post_reset_state got %h exp 0", {busy, sample_valid, overrun, sample_out});
    end
  endtask

  task automatic test_single_channel();
    int lat;
    logic [15:0] exp_s [3];
    exp_s = '{16'd0, 16'd1, 16'd2};
    do_reset();
    ch_en = 4'b0001;
    write_fcw(2'd0, 24'h010000);
    for (int k = 0; k < 3; k++) begin
      sweep(lat);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL single_latency[%0d] got %0d exp 5", k, lat);
      end
      checks++;
      if (sample_out !== exp_s[k]) begin
        errors++;
        $display("FAIL single_sample[%0d] got %h exp %h", k, sample_out, exp_s[k]);
      end
      step();
      checks++;
      if (sample_valid !== 1'b0 || sample_out !== exp_s[k] || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_hold[%0d] got v=%b s=%h b=%b exp v=0 s=%h b=0",
                 k, sample_valid, sample_out, busy, exp_s[k]);
      end
    end
  endtask

  task automatic test_phase_wrap();
    int lat;
    logic [7:0]  e0 [5];
    logic [7:0]  e1 [5];
    logic [15:0] es [5];
    e0 = '{8'h00, 8'h80, 8'h00, 8'h80, 8'h00};
    e1 = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    es = '{16'd0, 16'hFFC0, 16'hFF80, 16'hFF40, 16'd0};
    do_reset();
    ch_en = 4'b1111;
    write_fcw(2'd0, 24'h800000);
    write_fcw(2'd1, 24'h400000);
    for (int k = 0; k < 5; k++) begin
      sweep(lat);
      checks++;
      if (run_addr[0] !== e0[k] || run_addr[1] !== e1[k]) begin
        errors++;
        $display("FAIL wrap_addr[%0d] got %h/%h exp %h/%h", k, run_addr[0], run_addr[1],
                 e0[k], e1[k]);
      end
      checks++;
      if (lat !== 5 || sample_out !== es[k]) begin
        errors++;
        $display("FAIL wrap_sample[%0d] got lat=%0d s=%h exp lat=5 s=%h", k, lat,
                 sample_out, es[k]);
      end
    end
  endtask

  task automatic test_min_sum();
    int lat;
    do_reset();
    ch_en     = 4'b1111;
    lut_const = 1'b1;
    sweep(lat);
    checks++;
    if (lat !== 5 || sample_out !== 16'h8000) begin
      errors++;
      $display("FAIL min_sum got lat=%0d s=%h exp lat=5 s=8000", lat, sample_out);
    end
    lut_const = 1'b0;
  endtask

  task automatic test_overrun();
    int lat;
    logic bad;
    do_reset();
    ch_en = 4'b0001;
    write_fcw(2'd0, 24'h010000);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_initial got %b exp 0", overrun);
    end
    start_sweep();
    step();
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== 5 || sample_out !== 16'd0) begin
      errors++;
      $display("FAIL overrun_sweep got lat=%0d s=%h exp lat=5 s=0", lat, sample_out);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b exp 1", overrun);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || sample_valid !== 1'b0 || overrun !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL overrun_no_second_sweep got activity exp idle with sticky overrun");
    end
    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_cleared got %b exp 0", overrun);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    do_reset();
    ch_en = 4'b1111;
    for (int c = 0; c < 4; c++) write_fcw(2'(c), 24'h010000);
    sweep(lat);
    start_sweep();
    step();
    step();
    checks++;
    if (busy !== 1'b1 || lut_addr !== 8'h01) begin
      errors++;
      $display("FAIL midrun_pre got busy=%b addr=%h exp busy=1 addr=01", busy, lut_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b0 || lut_addr !== 8'h00) begin
      errors++;
      $display("FAIL midrun_async got busy=%b v=%b addr=%h exp 0 0 00", busy, sample_valid,
               lut_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) write_fcw(2'(c), 24'h010000);
    sweep(lat);
    checks++;
    if ({run_addr[0], run_addr[1], run_addr[2], run_addr[3]} !== 32'd0 ||
        sample_out !== 16'd0 || lat !== 5) begin
      errors++;
      $display("FAIL midrun_restart got %h %h %h %h s=%h lat=%0d exp all 0 lat=5",
               run_addr[0], run_addr[1], run_addr[2], run_addr[3], sample_out, lat);
    end
  endtask

  task automatic test_fcw_mid_sweep();
    int lat;
    logic [7:0] ea [3];
    ea = '{8'h01, 8'h02, 8'h12};
    do_reset();
    ch_en = 4'b0001;
    write_fcw(2'd0, 24'h010000);
    sweep(lat);
    for (int k = 0; k < 3; k++) begin
      start_sweep();
      if (k == 0) begin
        // Same edge as ch0's accumulate: that update must use the old FCW.
        fcw_wr_en   = 1'b1;
        fcw_wr_ch   = 2'd0;
        fcw_wr_data = 24'h100000;
        step();
        fcw_wr_en = 1'b0;
      end
      wait_valid(lat);
      checks++;
      if (run_addr[0] !== ea[k] || sample_out !== {8'd0, ea[k]}) begin
        errors++;
        $display("FAIL fcw_mid[%0d] got addr=%h s=%h exp %h", k, run_addr[0], sample_out,
                 ea[k]);
      end
    end
  endtask

`ifdef MULTI_NCO_PHASE_SYNC_EN
  task automatic test_phase_sync();
    int lat;
    do_reset();
    ch_en = 4'b1111;
    write_fcw(2'd1, 24'h400000);
    sweep(lat);
    start_sweep();
    step();
    checks++;
    if (lut_addr !== 8'h40) begin
      errors++;
      $display("FAIL sync_addr got %h exp 40", lut_addr);
    end
    phase_sync = 4'b0010;
    step();
    phase_sync = 4'b0000;
    wait_valid(lat);
    sweep(lat);
    checks++;
    if (run_addr[1] !== 8'h00) begin
      errors++;
      $display("FAIL sync_cleared got %h exp 00", run_addr[1]);
    end
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    edges       = 0;
    rst_n       = 1'b0;
    fcw_wr_en   = 1'b0;
    fcw_wr_ch   = '0;
    fcw_wr_data = '0;
    ch_en       = '0;
    next_sample = 1'b0;
    lut_const   = 1'b0;
`ifdef MULTI_NCO_PHASE_SYNC_EN
    phase_sync  = '0;
`endif
    for (int i = 0; i < 4; i++) run_addr[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_channel();
    test_phase_wrap();
    test_min_sum();
    test_overrun();
    test_reset_mid_run();
    test_fcw_mid_sweep();
`ifdef MULTI_NCO_PHASE_SYNC_EN
    test_phase_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
